// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and sizes for the two-requester memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W           = 30;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned WD_W             = 8;
    localparam int unsigned WD_LIMIT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_MEM_BUSY = 2'd2,
        ST_DONE     = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory port,
// alternating on ties and bounding each access with a Mem_Ack watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WD_LIMIT = WD_LIMIT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              IF_Read,
    input  logic [ADDR_W-1:0] IF_Address,
    output logic [DATA_W-1:0] IF_ReadData,
    output logic              IF_Ready,
    input  logic              MEM_Read,
    input  logic              MEM_Write,
    input  logic [ADDR_W-1:0] MEM_Address,
    input  logic [DATA_W-1:0] MEM_WriteData,
    input  logic [3:0]        MEM_ByteEn,
    output logic [DATA_W-1:0] MEM_ReadData,
    output logic              MEM_Ready,
    output logic              MEM_Stall_Controller,
    output logic              Bus_Error,
    output logic              Mem_Req,
    output logic              Mem_Wr,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WrData,
    output logic [3:0]        Mem_ByteEn,
    input  logic              Mem_Ack,
    input  logic [DATA_W-1:0] Mem_RdData
);

    // Expiry is flagged in the BUSY cycle whose increment would reach WD_LIMIT,
    // so Mem_Req is held for exactly WD_LIMIT cycles.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

    arb_state_e        state_q;
    grant_e            last_grant_q;
    logic [WD_W-1:0]   wd_q;
    logic [WD_W-1:0]   wd_d;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              if_ready_q;
    logic              mem_ready_q;
    logic              bus_error_q;
    logic              mem_req_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wrdata_q;
    logic [3:0]        mem_byteen_q;

    logic mem_pend;
    logic grant_mem;
    logic wd_expire;

    assign mem_pend  = MEM_Read | MEM_Write;
    assign grant_mem = mem_pend & (~IF_Read | (last_grant_q == GNT_IF));
    assign wd_expire = (wd_q == WD_LAST);
    assign wd_d      = wd_q + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_IF;
            wd_q         <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            bus_error_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wrdata_q <= '0;
            mem_byteen_q <= '0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            bus_error_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (mem_pend || IF_Read) begin
                        mem_req_q <= 1'b1;
                        wd_q      <= '0;
                        if (grant_mem) begin
                            state_q      <= ST_MEM_BUSY;
                            last_grant_q <= GNT_MEM;
                            mem_addr_q   <= MEM_Address;
                            mem_wrdata_q <= MEM_WriteData;
                            mem_byteen_q <= MEM_ByteEn;
                            mem_wr_q     <= MEM_Write;
                        end else begin
                            state_q      <= ST_IF_BUSY;
                            last_grant_q <= GNT_IF;
                            mem_addr_q   <= IF_Address;
                            mem_wrdata_q <= '0;
                            mem_byteen_q <= '1;
                            mem_wr_q     <= 1'b0;
                        end
                    end
                end
                ST_IF_BUSY, ST_MEM_BUSY: begin
                    // A late Ack still wins over a simultaneous expiry.
                    if (Mem_Ack || wd_expire) begin
                        state_q     <= ST_DONE;
                        mem_req_q   <= 1'b0;
                        bus_error_q <= ~Mem_Ack;
                        if (state_q == ST_IF_BUSY) begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= Mem_Ack ? Mem_RdData : '0;
                        end else begin
                            mem_ready_q <= 1'b1;
                            if (!mem_wr_q) begin
                                mem_rdata_q <= Mem_Ack ? Mem_RdData : '0;
                            end
                        end
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign IF_ReadData          = if_rdata_q;
    assign IF_Ready             = if_ready_q;
    assign MEM_ReadData         = mem_rdata_q;
    assign MEM_Ready            = mem_ready_q;
    assign MEM_Stall_Controller = mem_pend & ~mem_ready_q;
    assign Bus_Error            = bus_error_q;
    assign Mem_Req              = mem_req_q;
    assign Mem_Wr               = mem_wr_q;
    assign Mem_Addr             = mem_addr_q;
    assign Mem_WrData           = mem_wrdata_q;
    assign Mem_ByteEn           = mem_byteen_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WD_LIMIT, default 255: Mem_Ack watchdog limit in cycles, 1..255.
REQ-002 SHALL use one clock; reset is synchronous and active-low. Ports: clock input 1, the single clock; reset_n input 1, synchronous active-low reset.
REQ-003 SHALL have IF_Read  input  1  instruction fetch request, level, held until IF_Ready.
REQ-004 SHALL have IF_Address  input  30  instruction word address.
REQ-005 SHALL have IF_ReadData  output  32  fetched word, registered.
REQ-006 SHALL have IF_Ready  output  1  one-cycle completion pulse for fetch.
REQ-007 SHALL have MEM_Read, MEM_Write  input  1 each  data request, level, held until MEM_Ready.
REQ-008 SHALL have MEM_Address  input  30;  MEM_WriteData  input  32;  MEM_ByteEn  input  4.
REQ-009 SHALL have MEM_ReadData  output  32  loaded word, registered.
REQ-010 SHALL have MEM_Ready  output  1  one-cycle completion pulse for data access.
REQ-011 SHALL have MEM_Stall_Controller  output  1  data-stage stall to hazard unit.
REQ-012 SHALL have Bus_Error  output  1  one-cycle pulse, coincident with Ready, on watchdog expiry.
REQ-013 SHALL have the memory port: Mem_Req, Mem_Wr  output 1; Mem_Addr  output 30; Mem_WrData  output 32; Mem_ByteEn  output 4; Mem_Ack  input 1; Mem_RdData  input 32.

Function
REQ-014 SHALL implement FSM states IDLE, IF_BUSY, MEM_BUSY, DONE.
REQ-015 IDLE SHALL grant when a request is present: MEM only -> MEM_BUSY; IF only -> IF_BUSY; both -> the requester not granted last (last_grant register).
REQ-016 On grant, the block SHALL register address, write data, byte enables and Mem_Wr (1 for MEM_Write, else 0; IF is always a read). It SHALL assert Mem_Req from the next cycle and hold all memory-port outputs stable until Mem_Ack or watchdog expiry.
REQ-017 In a BUSY state, Mem_Ack=1 SHALL capture Mem_RdData into the granted requester's ReadData register on reads only; writes leave MEM_ReadData unchanged. Next state is DONE and Mem_Req deasserts in DONE.
REQ-018 DONE SHALL last exactly one cycle and assert the granted requester's Ready. Next state is IDLE; requests are not sampled in DONE.
REQ-019 Minimum latency: request seen in IDLE at cycle 0 -> Mem_Req at cycle 1 -> Ack at cycle 1 -> Ready at cycle 2.
REQ-020 Watchdog counter SHALL clear on entering BUSY and increment each BUSY cycle without Ack. At count==WD_LIMIT: drop Mem_Req, go to DONE, load ReadData with 0 (reads), pulse Bus_Error.
REQ-021 Ack in the same cycle as watchdog expiry SHALL be treated as a normal completion, with no Bus_Error.
REQ-022 MEM_Stall_Controller SHALL equal (MEM_Read|MEM_Write) & ~MEM_Ready, combinational.
REQ-023 MEM_Read and MEM_Write both high SHALL be treated as a write.
REQ-024 Mem_Ack outside a BUSY state SHALL be ignored.
REQ-025 last_grant SHALL update at each grant.

Reset
REQ-026 reset_n=0 at a clock edge SHALL force IDLE, including mid-transaction.
REQ-027 Reset SHALL drive Mem_Req=0, Mem_Wr=0, all Ready and Bus_Error outputs 0, both ReadData registers 0, watchdog 0, and last_grant=IF so that MEM wins the first tie.
REQ-028 Mem_Addr, Mem_WrData and Mem_ByteEn SHALL reset to 0.

Structure
REQ-029 A shared package SHALL hold the state encoding (2-bit), the grant encoding (IF=0, MEM=1), address/data widths (30/32) and the WD_LIMIT default.
REQ-030 The block SHALL be a single module with no sub-module; the watchdog is an inline 8-bit counter.

Verification
REQ-031 IF_Read only, Ack after 1 cycle, RdData=0x8C220004 -> IF_Ready at cycle 2, IF_ReadData=0x8C220004, Mem_Wr=0.
REQ-032 IF_Read and MEM_Read both asserted after reset -> MEM granted first, then IF; repeated ties alternate MEM, IF, MEM.
REQ-033 MEM_Write, addr 0x0000_0010, data 0xDEADBEEF, ByteEn 0x3 -> Mem_Wr=1 and fields stable until Ack; MEM_ReadData unchanged; MEM_Stall_Controller high until the MEM_Ready cycle.
REQ-034 MEM_Read with no Ack, WD_LIMIT=4 -> Mem_Req drops after 4 BUSY cycles; MEM_Ready and Bus_Error pulse together; MEM_ReadData=0.
REQ-035 Ack coincident with watchdog expiry -> normal data captured, Bus_Error=0.
REQ-036 reset_n=0 during IF_BUSY -> next cycle IDLE, Mem_Req=0, no Ready pulse; a stray Ack afterwards is ignored.
